// File: rtl/mac_tx.sv
// mac_tx: transmit MAC framer (preamble, SFD, header, payload, zero pad, CRC-32 FCS, inter-packet gap)
// Ports:
//   in_txc, in_rst_n                          byte clock, synchronous active-low reset
//   in_start, in_dest_mac, in_src_mac,
//   in_ether_type                             frame request and header, sampled together in IDLE
//   in_valid, in_data, in_last, out_ready     payload byte stream
//   out_busy                                  high whenever not IDLE
//   out_txen, out_txd, out_txer               registered GMII-style PHY transmit interface
//   out_oversize                              pulse when payload is truncated at MAX_PAYLOAD
module mac_tx #(
   parameter logic [7:0] PREAMBLE_BYTE = 8'hAA,
   parameter logic [7:0] SFD_BYTE      = 8'hD5,
   parameter int         MIN_PAYLOAD   = 46,
   parameter int         MAX_PAYLOAD   = 1500,
   parameter int         IPG_BYTES     = 12
) (
   input  logic        in_txc,
   input  logic        in_rst_n,
   input  logic        in_start,
   input  logic [47:0] in_dest_mac,
   input  logic [47:0] in_src_mac,
   input  logic [15:0] in_ether_type,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   output logic        out_ready,
   output logic        out_busy,
   output logic        out_txen,
   output logic [7:0]  out_txd,
   output logic        out_txer,
   output logic        out_oversize
);
   typedef enum logic [3:0] {IDLE, PRE, SFD, DEST, SRC, TYPE, PAYLOAD, PAD, FCS, IPG} state_t;
   localparam logic [10:0] MIN_P    = 11'(MIN_PAYLOAD);
   localparam logic [10:0] MAX_P    = 11'(MAX_PAYLOAD);
   localparam logic [3:0]  IPG_LAST = 4'(IPG_BYTES - 1);
   state_t state, nxt_state;
   logic [3:0] cnt, nxt_cnt;
   logic [10:0] pcnt, nxt_pcnt, pcnt_inc;
   logic [31:0] crc, nxt_crc;
   logic [111:0] hdr, nxt_hdr;
   logic nxt_txen, nxt_txer, nxt_ovs;
   logic [7:0] nxt_txd;
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
      return r;
   endfunction
   assign pcnt_inc = pcnt + 11'd1;
   assign out_ready = state == PAYLOAD;
   assign out_busy = state != IDLE;
   // header is held as one shift register so DEST, SRC and TYPE all send its top byte
   always_comb begin
      nxt_state = state;
      nxt_cnt = cnt + 4'd1;
      nxt_pcnt = pcnt;
      nxt_crc = crc;
      nxt_hdr = hdr;
      nxt_txen = 1'b1;
      nxt_txd = 8'h00;
      nxt_txer = 1'b0;
      nxt_ovs = 1'b0;
      case (state)
         IDLE: begin
            nxt_txen = 1'b0;
            nxt_cnt = 4'd0;
            if (in_start) begin
               nxt_state = PRE;
               nxt_pcnt = 11'd0;
               nxt_crc = '1;
               nxt_hdr = {in_dest_mac, in_src_mac, in_ether_type};
            end
         end
         PRE: begin
            nxt_txd = PREAMBLE_BYTE;
            if (cnt == 4'd6) begin
               nxt_state = SFD;
               nxt_cnt = 4'd0;
            end
         end
         SFD: begin
            nxt_txd = SFD_BYTE;
            nxt_state = DEST;
            nxt_cnt = 4'd0;
         end
         DEST, SRC, TYPE: begin
            nxt_txd = hdr[111:104];
            nxt_hdr = hdr << 8;
            nxt_crc = crc_byte(crc, hdr[111:104]);
            if (cnt == (state == TYPE ? 4'd1 : 4'd5)) begin
               nxt_state = state == DEST ? SRC : state == SRC ? TYPE : PAYLOAD;
               nxt_cnt = 4'd0;
            end
         end
         PAYLOAD: begin
            nxt_cnt = 4'd0;
            if (in_valid) begin
               nxt_txd = in_data;
               nxt_crc = crc_byte(crc, in_data);
               nxt_pcnt = pcnt_inc;
               if (in_last) nxt_state = pcnt_inc < MIN_P ? PAD : FCS;
               else if (pcnt_inc == MAX_P) begin
                  nxt_state = FCS;
                  nxt_ovs = 1'b1;
               end
            end else begin
               nxt_txer = 1'b1;
               nxt_state = IPG;
            end
         end
         PAD: begin
            nxt_cnt = 4'd0;
            nxt_crc = crc_byte(crc, 8'h00);
            nxt_pcnt = pcnt_inc;
            if (pcnt_inc == MIN_P) nxt_state = FCS;
         end
         FCS: begin
            nxt_txd = ~crc[{cnt[1:0], 3'd0} +: 8];
            if (cnt == 4'd3) begin
               nxt_state = IPG;
               nxt_cnt = 4'd0;
            end
         end
         IPG: begin
            nxt_txen = 1'b0;
            if (cnt == IPG_LAST) begin
               nxt_state = IDLE;
               nxt_cnt = 4'd0;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end
   always_ff @(posedge in_txc) begin
      if (!in_rst_n) begin
         state <= IDLE;
         cnt <= 4'd0;
         pcnt <= 11'd0;
         crc <= 32'd0;
         hdr <= '0;
         out_txen <= 1'b0;
         out_txd <= 8'h00;
         out_txer <= 1'b0;
         out_oversize <= 1'b0;
      end else begin
         state <= nxt_state;
         cnt <= nxt_cnt;
         pcnt <= nxt_pcnt;
         crc <= nxt_crc;
         hdr <= nxt_hdr;
         out_txen <= nxt_txen;
         out_txd <= nxt_txd;
         out_txer <= nxt_txer;
         out_oversize <= nxt_ovs;
      end
   end
endmodule

// File: tb/tb_mac_tx.sv
// tb_mac_tx: directed self-checking bench for mac_tx with a CRC-32 reference model
module tb_mac_tx;
   logic clk = 1'b0;
   logic rst_n, start, valid, last;
   logic [47:0] dest, src;
   logic [15:0] et;
   logic [7:0] data;
   logic ready, busy, txen, txer, ovs;
   logic [7:0] txd;
   int checks = 0, failures = 0;
   logic [7:0] pl [0:1500];
   logic [7:0] got_q [$];
   logic [7:0] exp_q [$];
   int txen_cyc, low_cyc, reen, txer_cnt, txer_pos, ovs_cnt, ovs_pos, ovs_rdy, idx, timeout;
   always #5 clk = ~clk;
   mac_tx dut (
      .in_txc(clk), .in_rst_n(rst_n), .in_start(start),
      .in_dest_mac(dest), .in_src_mac(src), .in_ether_type(et),
      .in_valid(valid), .in_data(data), .in_last(last),
      .out_ready(ready), .out_busy(busy), .out_txen(txen), .out_txd(txd),
      .out_txer(txer), .out_oversize(ovs)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      logic fb;
      r = c;
      for (int i = 0; i < 8; i++) begin
         fb = r[0] ^ d[i];
         r = {1'b0, r[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
      end
      return r;
   endfunction
   task automatic build_exp(input int n, input bit has_last, input int und);
      logic [31:0] c;
      logic [111:0] h;
      logic [7:0] b;
      int m;
      c = '1;
      h = {dest, src, et};
      exp_q.delete();
      repeat (7) exp_q.push_back(8'hAA);
      exp_q.push_back(8'hD5);
      for (int i = 0; i < 14; i++) begin
         b = h[111 - 8 * i -: 8];
         exp_q.push_back(b);
         c = crc_upd(c, b);
      end
      if (und >= 0) begin
         for (int i = 0; i < und; i++) exp_q.push_back(pl[i]);
         exp_q.push_back(8'h00);
         return;
      end
      m = has_last ? n : 1500;
      for (int i = 0; i < m; i++) begin
         exp_q.push_back(pl[i]);
         c = crc_upd(c, pl[i]);
      end
      for (int i = m; i < 46; i++) begin
         exp_q.push_back(8'h00);
         c = crc_upd(c, 8'h00);
      end
      for (int i = 0; i < 4; i++) exp_q.push_back(~c[8 * i +: 8]);
   endtask
   task automatic run_frame(input int n, input bit has_last, input int und, input bit ipg_start);
      bit sent;
      logic rdy;
      sent = 1'b0;
      got_q.delete();
      txen_cyc = 0; low_cyc = 0; reen = 0; txer_cnt = 0; txer_pos = -1;
      ovs_cnt = 0; ovs_pos = -1; ovs_rdy = 0; idx = 0; timeout = 1;
      @(negedge clk);
      start = 1'b1; valid = 1'b0; last = 1'b0;
      @(posedge clk); #1;
      check("start_busy", busy, 1);
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         start = ipg_start && sent && !txen;
         valid = idx < n && idx != und;
         data = pl[idx];
         last = has_last && idx == n - 1;
         rdy = ready;
         @(posedge clk); #1;
         if (rdy && valid) idx++;
         if (txen) begin
            if (low_cyc > 0) reen++;
            sent = 1'b1;
            txen_cyc++;
            got_q.push_back(txd);
         end else if (sent) low_cyc++;
         if (txer) begin
            txer_cnt++;
            txer_pos = got_q.size() - 1;
         end
         if (ovs) begin
            ovs_cnt++;
            ovs_pos = got_q.size() - 1;
         end
         if (ovs_cnt > 0 && ready) ovs_rdy++;
         if (sent && !busy) begin
            timeout = 0;
            break;
         end
      end
      check("timeout", timeout, 0);
      start = 1'b0; valid = 1'b0; last = 1'b0;
   endtask
   task automatic compare_frame(input string name);
      int f0;
      check({name, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         f0 = failures;
         check($sformatf("%s_b%0d", name, i), got_q[i], exp_q[i]);
         if (failures != f0) break;
      end
   endtask
   task automatic residue(input string name);
      logic [31:0] c;
      c = '1;
      for (int i = 8; i < got_q.size(); i++) c = crc_upd(c, got_q[i]);
      check({name, "_residue"}, c, 32'hDEBB20E3);
   endtask
   initial begin
      rst_n = 1'b0; start = 1'b0; valid = 1'b0; last = 1'b0; data = 8'h00;
      dest = '0; src = '0; et = '0;
      repeat (3) begin
         @(posedge clk); #1;
         check("rst_out", {txen, busy, ready, txer, ovs, txd}, 0);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         check("idle_out", {txen, busy, ready, txer, ovs, txd}, 0);
      end
      dest = 48'hFFFFFFFFFFFF; src = 48'h020000000001; et = 16'h0800;
      pl[0] = 8'h5A;
      build_exp(1, 1'b1, -1);
      run_frame(1, 1'b1, -1, 1'b1);
      compare_frame("min");
      residue("min");
      check("min_txen", txen_cyc, 72);
      check("min_ipg", low_cyc, 12);
      check("min_reen", reen, 0);
      check("min_txer", txer_cnt, 0);
      check("min_ovs", ovs_cnt, 0);
      for (int i = 0; i < 100; i++) pl[i] = 8'(i);
      build_exp(100, 1'b1, -1);
      run_frame(100, 1'b1, -1, 1'b0);
      compare_frame("p100");
      residue("p100");
      check("p100_txen", txen_cyc, 126);
      check("p100_ipg", low_cyc, 12);
      build_exp(100, 1'b1, 10);
      run_frame(100, 1'b1, 10, 1'b0);
      compare_frame("und");
      check("und_txen", txen_cyc, 33);
      check("und_txer_cnt", txer_cnt, 1);
      check("und_txer_pos", txer_pos, 32);
      check("und_ipg", low_cyc, 12);
      for (int i = 0; i <= 1500; i++) pl[i] = 8'(i * 7 + 3);
      build_exp(1501, 1'b0, -1);
      run_frame(1501, 1'b0, -1, 1'b0);
      compare_frame("ovs");
      residue("ovs");
      check("ovs_cnt", ovs_cnt, 1);
      check("ovs_pos", ovs_pos, 1521);
      check("ovs_ready", ovs_rdy, 0);
      check("ovs_accepted", idx, 1500);
      check("ovs_txen", txen_cyc, 1526);
      dest = 48'h112233445566; src = 48'hA0B0C0D0E0F0; et = 16'h88B5;
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1;
      @(negedge clk) start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("dest_byte1", {txen, txd}, 9'h122);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrst_out", {txen, busy, ready}, 0);
      @(negedge clk) rst_n = 1'b1;
      pl[0] = 8'hC3;
      build_exp(1, 1'b1, -1);
      run_frame(1, 1'b1, -1, 1'b0);
      compare_frame("post_rst");
      residue("post_rst");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
